// File: rtl/slot_release_engine.sv
// Release-side companion to the HDU slot allocator: tracks leases from grants,
// turns completions and lease expiries into one registered free per cycle.
`ifndef HDU_MAX_SLOTS
`define HDU_MAX_SLOTS 4
`endif
`ifndef HDU_SLOT_ID_WIDTH
`define HDU_SLOT_ID_WIDTH 3
`endif

// state   | meaning
// IDLE    | slot free at the allocator, not tracked
// LEASED  | granted, lease counter running, waiting for done or expiry
// PENDING | finished or expired, queued for release to the allocator
module slot_release_engine #(
  parameter int MAX_SLOTS_P    = `HDU_MAX_SLOTS,
  parameter int LEASE_CYCLES_P = 1024,
  localparam int SLOT_W = `HDU_SLOT_ID_WIDTH,
  localparam int CNT_W  = $clog2(LEASE_CYCLES_P + 1),
  localparam int LCNT_W = $clog2(MAX_SLOTS_P + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   alloc_valid,
  input  logic                   alloc_success,
  input  logic [SLOT_W-1:0]      alloc_slot_id,
  input  logic                   done_valid,
  input  logic [SLOT_W-1:0]      done_slot_id,
  output logic                   free_en,
  output logic [SLOT_W-1:0]      free_slot_id,
  output logic [MAX_SLOTS_P-1:0] leased,
  output logic [LCNT_W-1:0]      lease_count,
  output logic                   timeout_pulse,
  output logic [SLOT_W-1:0]      timeout_slot_id,
  output logic                   spurious_done,
  output logic                   grant_err
);

  // A zero lease period would give a zero-width counter; keep at least one bit.
  localparam int CW = (CNT_W < 1) ? 1 : CNT_W;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] LEASED  = 2'd1;
  localparam logic [1:0] PENDING = 2'd2;

  logic [1:0]        st_q  [MAX_SLOTS_P];
  logic [1:0]        st_d  [MAX_SLOTS_P];
  logic [CW-1:0]     cnt_q [MAX_SLOTS_P];
  logic [CW-1:0]     cnt_d [MAX_SLOTS_P];

  logic              grant;
  logic              g_hit;
  logic              d_hit;
  logic              grant_ok;
  logic              done_ok;
  logic              exp_hit;
  logic [SLOT_W-1:0] exp_id;
  logic              rel_any;
  logic [SLOT_W-1:0] rel_id;
  logic [LCNT_W-1:0] count_d;

  assign grant = alloc_valid & alloc_success;

  // All decisions are taken against the pre-edge slot states.
  always_comb begin
    g_hit    = 1'b0;
    d_hit    = 1'b0;
    grant_ok = 1'b0;
    done_ok  = 1'b0;
    exp_hit  = 1'b0;
    exp_id   = '0;
    rel_any  = 1'b0;
    rel_id   = '0;
    count_d  = '0;
    for (int i = 0; i < MAX_SLOTS_P; i++) begin
      st_d[i]  = st_q[i];
      cnt_d[i] = cnt_q[i];
      g_hit    = grant && (alloc_slot_id == SLOT_W'(i));
      d_hit    = done_valid && (done_slot_id == SLOT_W'(i));
      case (st_q[i])
        IDLE: begin
          if (g_hit) begin
            st_d[i]  = LEASED;
            cnt_d[i] = CW'(LEASE_CYCLES_P);
            grant_ok = 1'b1;
          end
        end
        LEASED: begin
          if (cnt_q[i] != '0) cnt_d[i] = cnt_q[i] - CW'(1);
          if (d_hit) begin
            st_d[i] = PENDING;
            done_ok = 1'b1;
          end else if ((LEASE_CYCLES_P != 0) && (cnt_q[i] == CW'(1))) begin
            st_d[i] = PENDING;
            if (!exp_hit) begin
              exp_hit = 1'b1;
              exp_id  = SLOT_W'(i);
            end
          end
        end
        PENDING: begin
          if (d_hit) done_ok = 1'b1;
          if (!rel_any) begin
            rel_any  = 1'b1;
            rel_id   = SLOT_W'(i);
            st_d[i]  = IDLE;
            cnt_d[i] = '0;
          end
        end
        default: begin
          st_d[i]  = IDLE;
          cnt_d[i] = '0;
        end
      endcase
      count_d = count_d + LCNT_W'(st_d[i] != IDLE);
    end
  end

  always_comb begin
    for (int i = 0; i < MAX_SLOTS_P; i++) leased[i] = (st_q[i] != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MAX_SLOTS_P; i++) begin
        st_q[i]  <= IDLE;
        cnt_q[i] <= '0;
      end
      free_en         <= 1'b0;
      free_slot_id    <= '0;
      lease_count     <= '0;
      timeout_pulse   <= 1'b0;
      timeout_slot_id <= '0;
      spurious_done   <= 1'b0;
      grant_err       <= 1'b0;
    end else begin
      for (int i = 0; i < MAX_SLOTS_P; i++) begin
        st_q[i]  <= st_d[i];
        cnt_q[i] <= cnt_d[i];
      end
      free_en       <= rel_any;
      if (rel_any) free_slot_id <= rel_id;
      lease_count   <= count_d;
      timeout_pulse <= exp_hit;
      if (exp_hit) timeout_slot_id <= exp_id;
      spurious_done <= done_valid & ~done_ok;
      grant_err     <= grant & ~grant_ok;
    end
  end

endmodule

// File: tb/tb_slot_release_engine.sv
// Bench for slot_release_engine: fixed vector table, corner-case sequences and
// random traffic, all checked against a deadline-based lease model.
`ifndef HDU_MAX_SLOTS
`define HDU_MAX_SLOTS 4
`endif
`ifndef HDU_SLOT_ID_WIDTH
`define HDU_SLOT_ID_WIDTH 3
`endif

module tb_slot_release_engine;
  localparam int NS = 4;
  localparam int L  = 8;
  localparam int SW = `HDU_SLOT_ID_WIDTH;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          alloc_valid = 1'b0;
  logic          alloc_success = 1'b0;
  logic [SW-1:0] alloc_slot_id = '0;
  logic          done_valid = 1'b0;
  logic [SW-1:0] done_slot_id = '0;
  logic          free_en;
  logic [SW-1:0] free_slot_id;
  logic [NS-1:0] leased;
  logic [2:0]    lease_count;
  logic          timeout_pulse;
  logic [SW-1:0] timeout_slot_id;
  logic          spurious_done;
  logic          grant_err;

  slot_release_engine #(.MAX_SLOTS_P(NS), .LEASE_CYCLES_P(L)) dut (
    .clk(clk), .rst_n(rst_n),
    .alloc_valid(alloc_valid), .alloc_success(alloc_success), .alloc_slot_id(alloc_slot_id),
    .done_valid(done_valid), .done_slot_id(done_slot_id),
    .free_en(free_en), .free_slot_id(free_slot_id),
    .leased(leased), .lease_count(lease_count),
    .timeout_pulse(timeout_pulse), .timeout_slot_id(timeout_slot_id),
    .spurious_done(spurious_done), .grant_err(grant_err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Reference model: slot status plus the absolute edge at which a lease expires.
  localparam int M_IDLE = 0, M_LEASED = 1, M_PEND = 2;
  int mst [NS];
  int dl  [NS];
  int cyc = 0;
  int m_fe, m_fid, m_tp, m_tid, m_spur, m_gerr, m_cnt, m_leased;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NS; i++) begin
      mst[i] = M_IDLE;
      dl[i]  = 0;
    end
    m_fe = 0; m_fid = 0; m_tp = 0; m_tid = 0;
    m_spur = 0; m_gerr = 0; m_cnt = 0; m_leased = 0;
  endtask

  task automatic model_edge(input bit g, input int aid, input bit d, input int did);
    int nst [NS];
    bit released;
    cyc++;
    for (int i = 0; i < NS; i++) nst[i] = mst[i];
    m_fe = 0; m_tp = 0; m_spur = 0; m_gerr = 0;
    if (g) begin
      if (aid < NS && mst[aid] == M_IDLE) begin
        nst[aid] = M_LEASED;
        dl[aid]  = cyc + L;
      end else m_gerr = 1;
    end
    if (d) begin
      if (did < NS && mst[did] == M_LEASED) nst[did] = M_PEND;
      else if (!(did < NS && mst[did] == M_PEND)) m_spur = 1;
    end
    for (int i = 0; i < NS; i++)
      if (mst[i] == M_LEASED && L != 0 && cyc == dl[i] && !(d && did == i)) begin
        nst[i] = M_PEND;
        m_tp   = 1;
        m_tid  = i;
      end
    released = 0;
    for (int i = 0; i < NS; i++)
      if (!released && mst[i] == M_PEND) begin
        released = 1;
        nst[i]   = M_IDLE;
        m_fe     = 1;
        m_fid    = i;
      end
    m_cnt = 0;
    m_leased = 0;
    for (int i = 0; i < NS; i++) begin
      mst[i] = nst[i];
      if (nst[i] != M_IDLE) begin
        m_cnt++;
        m_leased = m_leased | (1 << i);
      end
    end
  endtask

  task automatic step(input int av, input int gs, input int aid, input int dv, input int did);
    alloc_valid   = (av != 0);
    alloc_success = (gs != 0);
    alloc_slot_id = SW'(aid);
    done_valid    = (dv != 0);
    done_slot_id  = SW'(did);
    @(posedge clk);
    model_edge(av != 0 && gs != 0, aid, dv != 0, did);
    #1;
    chk("free_en", int'(free_en), m_fe);
    chk("free_slot_id", int'(free_slot_id), m_fid);
    chk("leased", int'(leased), m_leased);
    chk("lease_count", int'(lease_count), m_cnt);
    chk("timeout_pulse", int'(timeout_pulse), m_tp);
    chk("timeout_slot_id", int'(timeout_slot_id), m_tid);
    chk("spurious_done", int'(spurious_done), m_spur);
    chk("grant_err", int'(grant_err), m_gerr);
    alloc_valid = 1'b0;
    done_valid  = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_free_en"}, int'(free_en), 0);
    chk({tag, "_free_slot_id"}, int'(free_slot_id), 0);
    chk({tag, "_leased"}, int'(leased), 0);
    chk({tag, "_lease_count"}, int'(lease_count), 0);
    chk({tag, "_timeout_pulse"}, int'(timeout_pulse), 0);
    chk({tag, "_timeout_slot_id"}, int'(timeout_slot_id), 0);
    chk({tag, "_spurious_done"}, int'(spurious_done), 0);
    chk({tag, "_grant_err"}, int'(grant_err), 0);
  endtask

  typedef struct {
    int av, gs, aid, dv, did;
    int fe, fid, lsd, cnt, tp, tid, spur, gerr;
  } vec_t;

  vec_t vt [21];

  initial begin
    // done path, spurious done, re-grant error with no counter reload, bad ids
    vt[0]  = '{1,1,2,0,0, 0,0,4,1,0,0,0,0};
    vt[1]  = '{0,0,0,0,0, 0,0,4,1,0,0,0,0};
    vt[2]  = '{0,0,0,0,0, 0,0,4,1,0,0,0,0};
    vt[3]  = '{0,0,0,1,2, 0,0,4,1,0,0,0,0};
    vt[4]  = '{0,0,0,0,0, 1,2,0,0,0,0,0,0};
    vt[5]  = '{0,0,0,0,0, 0,2,0,0,0,0,0,0};
    vt[6]  = '{0,0,0,1,3, 0,2,0,0,0,0,1,0};
    vt[7]  = '{0,0,0,0,0, 0,2,0,0,0,0,0,0};
    vt[8]  = '{1,1,0,0,0, 0,2,1,1,0,0,0,0};
    vt[9]  = '{1,1,0,0,0, 0,2,1,1,0,0,0,1};
    for (int i = 10; i < 16; i++) vt[i] = '{0,0,0,0,0, 0,2,1,1,0,0,0,0};
    vt[16] = '{0,0,0,0,0, 0,2,1,1,1,0,0,0};
    vt[17] = '{0,0,0,0,0, 1,0,0,0,0,0,0,0};
    vt[18] = '{0,0,0,1,5, 0,0,0,0,0,0,1,0};
    vt[19] = '{1,0,1,0,0, 0,0,0,0,0,0,0,0};
    vt[20] = '{1,1,6,0,0, 0,0,0,0,0,0,0,1};

    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst_n = 1'b1;

    for (int i = 0; i < 21; i++) begin
      step(vt[i].av, vt[i].gs, vt[i].aid, vt[i].dv, vt[i].did);
      chk($sformatf("vec%0d_free_en", i), int'(free_en), vt[i].fe);
      chk($sformatf("vec%0d_free_slot_id", i), int'(free_slot_id), vt[i].fid);
      chk($sformatf("vec%0d_leased", i), int'(leased), vt[i].lsd);
      chk($sformatf("vec%0d_lease_count", i), int'(lease_count), vt[i].cnt);
      chk($sformatf("vec%0d_timeout_pulse", i), int'(timeout_pulse), vt[i].tp);
      chk($sformatf("vec%0d_timeout_slot_id", i), int'(timeout_slot_id), vt[i].tid);
      chk($sformatf("vec%0d_spurious_done", i), int'(spurious_done), vt[i].spur);
      chk($sformatf("vec%0d_grant_err", i), int'(grant_err), vt[i].gerr);
    end

    // timeout path: grant slot 1, expiry reported after E0+8, free after E0+9
    step(1, 1, 1, 0, 0);
    for (int k = 1; k < L; k++) begin
      step(0, 0, 0, 0, 0);
      chk("to_no_early_pulse", int'(timeout_pulse), 0);
    end
    step(0, 0, 0, 0, 0);
    chk("to_pulse", int'(timeout_pulse), 1);
    chk("to_slot", int'(timeout_slot_id), 1);
    chk("to_no_free_yet", int'(free_en), 0);
    step(0, 0, 0, 0, 0);
    chk("to_free_en", int'(free_en), 1);
    chk("to_free_id", int'(free_slot_id), 1);
    chk("to_pulse_one_cycle", int'(timeout_pulse), 0);

    // arbiter: done 3 then done 0 on consecutive edges
    step(1, 1, 0, 0, 0);
    step(1, 1, 3, 0, 0);
    step(0, 0, 0, 1, 3);
    chk("arb_leased", int'(leased), 9);
    step(0, 0, 0, 1, 0);
    chk("arb_first_en", int'(free_en), 1);
    chk("arb_first_id", int'(free_slot_id), 3);
    step(0, 0, 0, 0, 0);
    chk("arb_second_en", int'(free_en), 1);
    chk("arb_second_id", int'(free_slot_id), 0);
    step(0, 0, 0, 0, 0);
    chk("arb_drained", int'(free_en), 0);
    chk("arb_count", int'(lease_count), 0);

    // arbiter: slot 3 expiry and done 0 on the same edge, lowest index first
    step(1, 1, 3, 0, 0);
    step(1, 1, 0, 0, 0);
    idle(L - 2);
    step(0, 0, 0, 1, 0);
    chk("arb2_timeout", int'(timeout_pulse), 1);
    chk("arb2_timeout_id", int'(timeout_slot_id), 3);
    step(0, 0, 0, 0, 0);
    chk("arb2_first_id", int'(free_slot_id), 0);
    chk("arb2_first_en", int'(free_en), 1);
    step(0, 0, 0, 0, 0);
    chk("arb2_second_id", int'(free_slot_id), 3);
    chk("arb2_second_en", int'(free_en), 1);
    idle(1);

    // done colliding with expiry, then a duplicate done
    step(1, 1, 2, 0, 0);
    idle(L - 1);
    step(0, 0, 0, 1, 2);
    chk("col_no_timeout", int'(timeout_pulse), 0);
    chk("col_pending", int'(leased), 4);
    step(0, 0, 0, 1, 2);
    chk("col_free_en", int'(free_en), 1);
    chk("col_free_id", int'(free_slot_id), 2);
    chk("col_dup_not_spurious", int'(spurious_done), 0);
    for (int k = 0; k < 4; k++) begin
      step(0, 0, 0, 0, 0);
      chk("col_single_free", int'(free_en), 0);
      chk("col_still_no_timeout", int'(timeout_pulse), 0);
    end

    // random traffic against the model
    for (int k = 0; k < 1500; k++)
      step(($urandom_range(0, 2) == 0) ? 1 : 0, ($urandom_range(0, 3) != 0) ? 1 : 0,
           int'($urandom_range(0, 4)), ($urandom_range(0, 3) == 0) ? 1 : 0,
           int'($urandom_range(0, 4)));

    // reset mid-lease
    idle(L + 6);
    step(1, 1, 0, 0, 0);
    step(1, 1, 1, 0, 0);
    idle(2);
    chk("rst_pre_leased", int'(leased), 3);
    #3;
    rst_n = 1'b0;
    #1;
    chk_all_zero("midrst");
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      step(0, 0, 0, 0, 0);
      chk("post_rst_no_free", int'(free_en), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
